jk_cmd_sequencer: RTL and testbench



---
 rtl/jk_cmd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding a downstream JK flip-flop: buffers {op,len} commands,
// replays them onto j/k back-to-back, and checks the returned q against a model.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     j,
  output logic                     k,
  input  logic                     q_fb,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = LEN_W + 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Length 0 behaves as length 1, so both load a zero remaining count.
  function automatic logic [LEN_W-1:0] first_rem(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] r;
    if (len == {LEN_W{1'b0}}) begin
      r = {LEN_W{1'b0}};
    end else begin
      r = len - LEN_W'(1);
    end
    return r;
  endfunction

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             exp_state_q, exp_state_d;
  logic             exp_valid_q, exp_valid_d;
  logic             err_q, err_d;

  logic             push_s, pop_s, empty_s, full_s;
  logic [1:0]       head_op_s;
  logic [LEN_W-1:0] head_len_s;

  assign empty_s    = (level_q == {LW{1'b0}});
  assign full_s     = (level_q == LW'(DEPTH));
  assign cmd_ready  = ~full_s;
  assign push_s     = cmd_valid & ~full_s;
  assign head_op_s  = mem_q[rd_ptr_q][EW-1:LEN_W];
  assign head_len_s = mem_q[rd_ptr_q][LEN_W-1:0];

  // Executor: pop the head whenever idle or on the last cycle of a command.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    j_d     = j_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_RUN;
          j_d     = head_op_s[1];
          k_d     = head_op_s[0];
          busy_d  = 1'b1;
          rem_d   = first_rem(head_len_s);
          done_d  = (head_len_s <= LEN_W'(1));
        end else begin
          j_d    = 1'b0;
          k_d    = 1'b0;
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (rem_q != {LEN_W{1'b0}}) begin
          rem_d  = rem_q - LEN_W'(1);
          done_d = (rem_q == LEN_W'(1));
        end else if (!empty_s) begin
          pop_s   = 1'b1;
          j_d     = head_op_s[1];
          k_d     = head_op_s[0];
          busy_d  = 1'b1;
          rem_d   = first_rem(head_len_s);
          done_d  = (head_len_s <= LEN_W'(1));
        end else begin
          state_d = ST_IDLE;
          j_d     = 1'b0;
          k_d     = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
        busy_d  = 1'b0;
        rem_d   = {LEN_W{1'b0}};
      end
    endcase
  end

  // FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Expected flip-flop state mirrors the JK capture of the current drive.
  always_comb begin
    exp_state_d = exp_state_q;
    case ({j_q, k_q})
      2'b01:   exp_state_d = 1'b0;
      2'b10:   exp_state_d = 1'b1;
      2'b11:   exp_state_d = ~exp_state_q;
      default: exp_state_d = exp_state_q;
    endcase
    exp_valid_d = exp_valid_q | (j_q ^ k_q);
    err_d       = err_q | (exp_valid_q & (q_fb != exp_state_q));
  end

  // All state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      state_q     <= ST_IDLE;
      rem_q       <= {LEN_W{1'b0}};
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exp_state_q <= 1'b0;
      exp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      j_q         <= j_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      exp_state_q <= exp_state_d;
      exp_valid_q <= exp_valid_d;
      err_q       <= err_d;
    end
  end

  assign j     = j_q;
  assign k     = k_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign level = level_q;
  assign err   = err_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop on the feedback path.
module tb_jk_cmd_sequencer;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       j, k, q_fb, busy, done, err;
  logic [2:0] level;

  logic q_ff = 1'b0;
  logic q_ovr = 1'b0;
  logic q_val = 1'b0;

  int checks = 0;
  int errors = 0;

  jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .q_fb(q_fb),
    .busy(busy), .done(done), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  // Downstream JK flip-flop model.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  assign q_fb = q_ovr ? q_val : q_ff;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] len,
                          output int waits, output int max_lvl);
    logic acc;
    acc = 1'b0;
    waits = 0;
    max_lvl = int'(level);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    for (int t = 0; t < 40; t++) begin
      acc = cmd_ready;
      @(posedge clk);
      @(negedge clk);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (acc) break;
      waits++;
    end
    cmd_valid = 1'b0;
    if (!acc) check_eq("push_timeout", {31'd0, acc}, 32'd1);
  endtask

  logic [1:0] b2b_op  [3] = '{OP_CLR, OP_TOG, OP_HOLD};
  logic [3:0] b2b_len [3] = '{4'd1, 4'd4, 4'd0};
  logic [1:0] b2b_jk  [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
  logic       b2b_dn  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int w, m, dn_cnt;
    #2;
    check_eq("rst_jk", {30'd0, j, k}, 32'd0);
    check_eq("rst_level", {29'd0, level}, 32'd0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unknown start: toggles leave the model invalid whatever q_fb does.
    q_ovr = 1'b1;
    q_val = 1'b1;
    push_cmd(OP_TOG, 4'd2, w, m);
    for (int n = 0; n < 4; n++) begin
      q_val = ~q_val;
      check_eq("unk_err", {31'd0, err}, 32'd0);
      check_eq("unk_expvalid", {31'd0, dut.exp_valid_q}, 32'd0);
      @(negedge clk);
    end
    push_cmd(OP_SET, 4'd1, w, m);
    q_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("set_expvalid", {31'd0, dut.exp_valid_q}, 32'd1);
    check_eq("set_q", {31'd0, q_ff}, 32'd1);
    check_eq("set_err", {31'd0, err}, 32'd0);

    // Single SET len=3.
    push_cmd(OP_SET, 4'd3, w, m);
    check_eq("single_pre_jk", {30'd0, j, k}, 32'd0);
    check_eq("single_pre_level", {29'd0, level}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_eq("single_jk", {30'd0, j, k}, 32'd2);
      check_eq("single_busy", {31'd0, busy}, 32'd1);
      check_eq("single_done", {31'd0, done}, (c == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check_eq("single_idle", {29'd0, busy, j, k}, 32'd0);
    check_eq("single_q", {31'd0, q_ff}, 32'd1);
    check_eq("single_err", {31'd0, err}, 32'd0);

    // Back-to-back CLR1, TOG4, HOLD0.
    dn_cnt = 0;
    for (int n = 0; n < 9; n++) begin
      if (n < 3) begin
        cmd_valid = 1'b1;
        cmd_op = b2b_op[n];
        cmd_len = b2b_len[n];
      end else begin
        cmd_valid = 1'b0;
      end
      if (n >= 2 && n < 8) begin
        check_eq("b2b_jk", {30'd0, j, k}, {30'd0, b2b_jk[n-2]});
        check_eq("b2b_done", {31'd0, done}, {31'd0, b2b_dn[n-2]});
        check_eq("b2b_busy", {31'd0, busy}, 32'd1);
        if (done) dn_cnt++;
      end
      if (n == 8) check_eq("b2b_idle", {29'd0, busy, j, k}, 32'd0);
      @(negedge clk);
    end
    check_eq("b2b_done_count", dn_cnt, 32'd3);
    check_eq("b2b_q", {31'd0, q_ff}, 32'd0);
    check_eq("b2b_err", {31'd0, err}, 32'd0);

    // Mismatch: SET captured, then q_fb forced low for one cycle.
    push_cmd(OP_SET, 4'd1, w, m);
    repeat (2) @(negedge clk);
    q_ovr = 1'b1;
    q_val = 1'b0;
    check_eq("mm_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    q_ovr = 1'b0;
    check_eq("mm_set", {31'd0, err}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("mm_sticky", {31'd0, err}, 32'd1);

    // Full FIFO behind a long HOLD.
    push_cmd(OP_HOLD, 4'd15, w, m);
    push_cmd(OP_SET, 4'd1, w, m);
    push_cmd(OP_CLR, 4'd1, w, m);
    push_cmd(OP_SET, 4'd1, w, m);
    push_cmd(OP_CLR, 4'd1, w, m);
    check_eq("full_level", {29'd0, level}, 32'd4);
    check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("full_busy", {31'd0, busy}, 32'd1);
    push_cmd(OP_SET, 4'd1, w, m);
    check_eq("full_waits", w, 32'd12);
    check_eq("full_peak", m, 32'd4);
    check_eq("full_after_level", {29'd0, level}, 32'd3);
    check_eq("full_after_jk", {30'd0, j, k}, 32'd1);
    check_eq("full_err_sticky", {31'd0, err}, 32'd1);

    // Asynchronous reset mid-RUN with 3 entries queued.
    rst_n = 1'b0;
    #1;
    check_eq("mrst_jk", {30'd0, j, k}, 32'd0);
    check_eq("mrst_level", {29'd0, level}, 32'd0);
    check_eq("mrst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("mrst_err", {31'd0, err}, 32'd0);
    check_eq("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stale entries must be gone: a fresh CLR1 runs alone.
    push_cmd(OP_CLR, 4'd1, w, m);
    @(negedge clk);
    check_eq("post_jk", {30'd0, j, k}, 32'd1);
    check_eq("post_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_eq("post_idle", {29'd0, busy, j, k}, 32'd0);
    check_eq("post_level", {29'd0, level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
